// File: rtl/dma_engine_pkg.sv
// Shared definitions for the DMA engine: word width, FSM encodings, command payload.
// DMA_CYCLE_STEAL_EN adds the RELEASE state and the burst length used between bus releases.
package dma_engine_pkg;

  localparam int unsigned WORD_SIZE = 16;

  localparam logic [2:0] DMA_IDLE    = 3'd0;
  localparam logic [2:0] DMA_REQ     = 3'd1;
  localparam logic [2:0] DMA_XFER    = 3'd2;
  localparam logic [2:0] DMA_DONE    = 3'd4;
`ifdef DMA_CYCLE_STEAL_EN
  localparam logic [2:0] DMA_RELEASE = 3'd3;
  localparam int unsigned DMA_BURST_LEN = 4;
`endif

  typedef logic [WORD_SIZE-1:0] dma_word_t;

  // Field order matches the cpu DMA_command bus: {valid, dest base, length}
  typedef struct packed {
    logic      valid;
    dma_word_t addr;
    dma_word_t len;
  } dma_cmd_t;

endpackage

// File: rtl/dma_engine_if.sv
// cpu <-> DMA engine handshake plus the device-buffer read port.
interface dma_engine_if;
  import dma_engine_pkg::*;

  dma_cmd_t  DMA_command;
  logic      Bus_Request;
  logic      Bus_Grant;
  logic      DMA_end;
  logic      mem_ready;
  dma_word_t dev_addr;
  dma_word_t dev_data;

  modport master (
    input  DMA_command, Bus_Grant, mem_ready, dev_data,
    output Bus_Request, DMA_end, dev_addr
  );

  modport slave (
    output DMA_command, Bus_Grant, mem_ready, dev_data,
    input  Bus_Request, DMA_end, dev_addr
  );

endinterface

// File: rtl/dma_engine.sv
// DMA engine: copies a device buffer into data memory over the shared d_* bus.
// Define DMA_CYCLE_STEAL_EN to release the bus for one cycle after every BURST_LEN words.
module dma_engine
  import dma_engine_pkg::*;
`ifdef DMA_CYCLE_STEAL_EN
#(
  parameter int unsigned BURST_LEN = DMA_BURST_LEN
)
`endif
(
  input  logic                 Clk,
  input  logic                 Reset_N,
  dma_engine_if.master         bus,
  output wire                  d_writeM,
  output wire [WORD_SIZE-1:0]  d_address,
  output wire [WORD_SIZE-1:0]  d_data
);

`ifdef DMA_CYCLE_STEAL_EN
  localparam int unsigned BURST_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  logic [BURST_W-1:0] beat, beat_nx;
`endif

  logic [2:0] state, state_nx;
  dma_word_t  base, base_nx;
  dma_word_t  len, len_nx;
  dma_word_t  idx, idx_nx;
  logic       bus_request_q, bus_request_nx;
  logic       dma_end_q, dma_end_nx;
  logic       last_word_c;
  wire        own_bus;

  assign own_bus     = (state == DMA_XFER) && bus.Bus_Grant;
  assign last_word_c = (idx == (len - dma_word_t'(1)));

  // Next-state and registered-output decode
  always_comb begin
    state_nx = state;
    base_nx  = base;
    len_nx   = len;
    idx_nx   = idx;
`ifdef DMA_CYCLE_STEAL_EN
    beat_nx  = beat;
`endif
    unique case (state)
      DMA_IDLE: begin
        if (bus.DMA_command.valid) begin
          base_nx  = bus.DMA_command.addr;
          len_nx   = bus.DMA_command.len;
          idx_nx   = '0;
`ifdef DMA_CYCLE_STEAL_EN
          beat_nx  = '0;
`endif
          state_nx = (bus.DMA_command.len == '0) ? DMA_DONE : DMA_REQ;
        end
      end
      DMA_REQ: begin
        if (bus.Bus_Grant) state_nx = DMA_XFER;
      end
      DMA_XFER: begin
        // A lost grant abandons the current word; it is retried at the same idx
        if (!bus.Bus_Grant) begin
          state_nx = DMA_REQ;
        end else if (bus.mem_ready) begin
          if (last_word_c) begin
            state_nx = DMA_DONE;
          end else begin
            idx_nx = idx + dma_word_t'(1);
`ifdef DMA_CYCLE_STEAL_EN
            beat_nx = beat + BURST_W'(1);
            if (beat == BURST_W'(BURST_LEN - 1)) begin
              beat_nx  = '0;
              state_nx = DMA_RELEASE;
            end
`endif
          end
        end
      end
`ifdef DMA_CYCLE_STEAL_EN
      DMA_RELEASE: begin
        state_nx = DMA_REQ;
      end
`endif
      DMA_DONE: begin
        idx_nx   = '0;
        state_nx = DMA_IDLE;
      end
      default: begin
        state_nx = DMA_IDLE;
      end
    endcase

    bus_request_nx = (state_nx == DMA_REQ) || (state_nx == DMA_XFER);
    dma_end_nx     = (state_nx == DMA_DONE);
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state         <= DMA_IDLE;
      base          <= '0;
      len           <= '0;
      idx           <= '0;
      bus_request_q <= 1'b0;
      dma_end_q     <= 1'b0;
`ifdef DMA_CYCLE_STEAL_EN
      beat          <= '0;
`endif
    end else begin
      state         <= state_nx;
      base          <= base_nx;
      len           <= len_nx;
      idx           <= idx_nx;
      bus_request_q <= bus_request_nx;
      dma_end_q     <= dma_end_nx;
`ifdef DMA_CYCLE_STEAL_EN
      beat          <= beat_nx;
`endif
    end
  end

  assign bus.Bus_Request = bus_request_q;
  assign bus.DMA_end     = dma_end_q;
  assign bus.dev_addr    = idx;

  // Memory bus is driven only while the engine owns it; the cpu floats d_* under grant
  assign d_writeM  = own_bus ? 1'b1        : 1'bz;
  assign d_address = own_bus ? base + idx  : 'z;
  assign d_data    = own_bus ? bus.dev_data : 'z;

endmodule

// File: tb/tb_dma_engine.sv
// Randomized scoreboard bench for dma_engine: cpu/memory/device models plus a negedge monitor.
// Build with DMA_CYCLE_STEAL_EN to expect one-cycle bus releases between bursts.
module tb_dma_engine;
  import dma_engine_pkg::*;

  localparam int BL = 4;

  logic Clk = 1'b0;
  logic Reset_N = 1'b0;
  always #5 Clk = ~Clk;

  dma_engine_if bus();
  wire                 d_writeM;
  wire [WORD_SIZE-1:0] d_address;
  wire [WORD_SIZE-1:0] d_data;

  dma_engine dut (
    .Clk       (Clk),
    .Reset_N   (Reset_N),
    .bus       (bus),
    .d_writeM  (d_writeM),
    .d_address (d_address),
    .d_data    (d_data)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [31:0] exp_wr_q[$];
  int          exp_end_q[$];
  dma_word_t   dev_mem [0:65535];

  int  wr_cnt = 0, low_cnt = 0, last_wr_cyc = 0, cmd_cyc = 0;
  bit  req_seen = 0, req_any = 0, pend_prev = 0;
  dma_word_t prev_addr;
  int  grant_delay = 2, rdy_mode = 0, drop_at_wr = -1, drop_timer = 0, rdy_cnt = 0, gcnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
  endtask

  // Device buffer: combinational read
  assign bus.dev_data = dev_mem[bus.dev_addr];

  // cpu grant and memory ready models, driven just after the active edge
  always @(posedge Clk) begin
    #1;
    if (drop_at_wr >= 0 && wr_cnt == drop_at_wr && d_writeM === 1'b1) begin
      drop_timer = 3;
      drop_at_wr = -1;
    end
    if (!Reset_N || !bus.Bus_Request || drop_timer > 0) begin
      bus.Bus_Grant = 1'b0;
      gcnt = 0;
      if (drop_timer > 0) drop_timer--;
    end else if (gcnt >= grant_delay) begin
      bus.Bus_Grant = 1'b1;
    end else begin
      gcnt++;
    end
    case (rdy_mode)
      0:       bus.mem_ready = 1'b1;
      1:       begin bus.mem_ready = (rdy_cnt % 3 == 2); rdy_cnt++; end
      default: bus.mem_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: everything the next edge will act on is stable here
  always @(negedge Clk) begin
    logic [31:0] e;
    int l, gaps;
    cyc++;
    if (!Reset_N) begin
      pend_prev = 1'b0;
    end else begin
      if (bus.Bus_Request) begin
        req_any = 1'b1;
        if (exp_wr_q.size() > 0) req_seen = 1'b1;
      end else if (req_seen && exp_wr_q.size() > 0) begin
        low_cnt++;
      end
      if (!bus.Bus_Grant) check("float_without_grant", 32'(d_writeM === 1'b1), 32'd0);
      if (pend_prev && d_writeM === 1'b1) check("addr_hold", 32'(d_address), 32'(prev_addr));
      pend_prev = (d_writeM === 1'b1) && !bus.mem_ready;
      prev_addr = d_address;
      if (d_writeM === 1'b1 && bus.mem_ready) begin
        if (exp_wr_q.size() == 0) fail("spurious_write", {d_address, d_data}, 32'd0);
        else begin
          e = exp_wr_q.pop_front();
          check("write_addr_data", {d_address, d_data}, e);
        end
        wr_cnt++;
        last_wr_cyc = cyc;
      end
      if (bus.DMA_end) begin
        if (exp_end_q.size() == 0) fail("spurious_end", 32'(cyc), 32'd0);
        else begin
          l = exp_end_q.pop_front();
          check("end_writes_left", 32'(exp_wr_q.size()), 32'd0);
          if (l > 0) begin
            gaps = 0;
`ifdef DMA_CYCLE_STEAL_EN
            gaps = (l - 1) / BL;
`endif
            check("end_latency", 32'(cyc - last_wr_cyc), 32'd1);
            check("req_gaps", 32'(low_cnt), 32'(gaps));
          end else begin
            check("zero_len_req", 32'(req_any), 32'd0);
            check("zero_len_latency", 32'(cyc - cmd_cyc), 32'd2);
          end
        end
        low_cnt  = 0;
        req_seen = 1'b0;
      end
    end
  end

  // Reference: word i of the buffer lands at base+i (16-bit wrap)
  task automatic issue(input dma_word_t base, input dma_word_t len);
    for (int i = 0; i < int'(len); i++) begin
      dev_mem[i] = 16'($urandom);
      exp_wr_q.push_back({base + 16'(i), dev_mem[i]});
    end
    exp_end_q.push_back(int'(len));
    wr_cnt = 0; low_cnt = 0; req_seen = 1'b0; req_any = 1'b0; cmd_cyc = cyc;
    bus.DMA_command = '{valid: 1'b1, addr: base, len: len};
    @(posedge Clk); #1;
    bus.DMA_command.valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (exp_end_q.size() != 0 && n < 2000) begin
      @(posedge Clk); #1;
      n++;
    end
    if (exp_end_q.size() != 0) begin
      fail({name, "_timeout"}, 32'(exp_wr_q.size()), 32'd0);
      exp_wr_q.delete();
      exp_end_q.delete();
    end
  endtask

  initial begin
    int n;
    bus.DMA_command = '0;
    #12;
    check("rst_bus_request", 32'(bus.Bus_Request), 32'd0);
    check("rst_dma_end", 32'(bus.DMA_end), 32'd0);
    check("rst_dev_addr", 32'(bus.dev_addr), 32'd0);
    check("rst_float", 32'(d_writeM === 1'b1), 32'd0);
    @(posedge Clk); #1;
    Reset_N = 1'b1;
    @(posedge Clk); #1;

    // 12-word copy, grant after 2 cycles, memory always ready
    grant_delay = 2; rdy_mode = 0;
    issue(16'h01F4, 16'd12);
    wait_done("t1");

    // zero-length command, issued back-to-back in the IDLE cycle
    issue(16'h1234, 16'd0);
    wait_done("t2");

    // slow memory: ready every 3rd cycle
    rdy_mode = 1;
    issue(16'h0100, 16'd4);
    wait_done("t3");
    check("t3_write_count", 32'(wr_cnt), 32'd4);

    // address wraps past 0xFFFF
    rdy_mode = 2;
    issue(16'hFFFE, 16'd5);
    wait_done("wrap");

    // grant dropped during word 5, plus a command that must be ignored mid-transfer
    grant_delay = 1; drop_at_wr = 4;
    issue(16'h0200, 16'd10);
    @(posedge Clk); #1;
    bus.DMA_command = '{valid: 1'b1, addr: 16'hDEAD, len: 16'd3};
    @(posedge Clk); #1;
    bus.DMA_command.valid = 1'b0;
    wait_done("t4");
    check("t4_write_count", 32'(wr_cnt), 32'd10);

    // asynchronous reset in the middle of a transfer
    rdy_mode = 0; grant_delay = 1;
    issue(16'h0300, 16'd10);
    n = 0;
    while (wr_cnt < 3 && n < 200) begin @(posedge Clk); #1; n++; end
    if (wr_cnt < 3) fail("t5_reach_xfer", 32'(wr_cnt), 32'd3);
    #2;
    Reset_N = 1'b0;
    #1;
    check("t5_rst_bus_request", 32'(bus.Bus_Request), 32'd0);
    check("t5_rst_dma_end", 32'(bus.DMA_end), 32'd0);
    check("t5_rst_dev_addr", 32'(bus.dev_addr), 32'd0);
    check("t5_rst_float", 32'(d_writeM === 1'b1), 32'd0);
    exp_wr_q.delete();
    exp_end_q.delete();
    repeat (2) @(posedge Clk);
    #1;
    Reset_N = 1'b1;
    @(posedge Clk); #1;
    issue(16'h0400, 16'd6);
    wait_done("t5_after");

    // randomized back-to-back commands
    for (int k = 0; k < 10; k++) begin
      grant_delay = $urandom_range(0, 3);
      rdy_mode    = $urandom_range(0, 2);
      issue(16'($urandom), ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 20)));
      wait_done("rand");
    end

    repeat (3) @(posedge Clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
